// File: rtl/path_decoder_pkg.sv
// Shared types and constants for the path decoder: FSM states, move codes
// and the location width ({x[7:4], y[3:0]}).
package path_decoder_pkg;

    localparam int LOCW = 8;

    typedef enum logic [1:0] {
        REC = 2'd0,
        RUN = 2'd1,
        FIN = 2'd2,
        ERR = 2'd3
    } state_t;

    localparam logic [1:0] DIR_YM = 2'b00;  // y-1
    localparam logic [1:0] DIR_XP = 2'b01;  // x+1
    localparam logic [1:0] DIR_XM = 2'b10;  // x-1
    localparam logic [1:0] DIR_YP = 2'b11;  // y+1

endpackage

// File: rtl/path_decoder_loc_pair_decode.sv
// Combinational decode of one step between two recorded locations.
// Coordinate differences wrap modulo 2^(LOCW/2), so 0 -> 15 is a step of -1.
module loc_pair_decode #(
    parameter int LOCW = path_decoder_pkg::LOCW
) (
    input  logic [LOCW-1:0] a,
    input  logic [LOCW-1:0] b,
    output logic [1:0]      dir,
    output logic            ok
);
    import path_decoder_pkg::*;

    localparam int HW = LOCW / 2;

    logic [HW-1:0] dx;
    logic [HW-1:0] dy;

    // Classify the b-a difference as one of the four unit moves, else not ok
    always_comb begin
        dx  = b[LOCW-1:HW] - a[LOCW-1:HW];
        dy  = b[HW-1:0] - a[HW-1:0];
        dir = DIR_YM;
        ok  = 1'b0;
        if (dy == '0) begin
            if (dx == HW'(1)) begin
                dir = DIR_XP;
                ok  = 1'b1;
            end else if (dx == '1) begin
                dir = DIR_XM;
                ok  = 1'b1;
            end
        end else if (dx == '0) begin
            if (dy == HW'(1)) begin
                dir = DIR_YP;
                ok  = 1'b1;
            end else if (dy == '1) begin
                dir = DIR_YM;
                ok  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/path_decoder.sv
// Path decoder: records a stack of grid locations (push records a step,
// pop backtracks) and replays the path bottom-to-top as a stream of move
// codes with valid/ready handshaking. A non-adjacent pair traps in ERR.
module path_decoder #(
    parameter int DEPTH = 16,
    parameter int LOCW  = path_decoder_pkg::LOCW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [LOCW-1:0] locIn,
    input  logic            start,
    input  logic            ready,
    output logic            valid,
    output logic [1:0]      dir,
    output logic            done,
    output logic            err,
    output logic            full,
    output logic            empty
);
    import path_decoder_pkg::*;

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   count;
    logic [PW-1:0]   count_next;
    logic [PW-1:0]   count_m1;
    logic [PW-1:0]   rd_idx;
    logic [PW-1:0]   rd_idx_next;
    logic [PW-1:0]   rd_nxt;
    logic [LOCW-1:0] mem [DEPTH];
    logic            wr_en;
    logic [IW-1:0]   wr_addr;
    logic [1:0]      pair_dir;
    logic            pair_ok;

    assign count_m1 = count - PW'(1);
    assign rd_nxt   = rd_idx + PW'(1);
    assign full     = (count == PW'(DEPTH));
    assign empty    = (count == '0);

    loc_pair_decode #(.LOCW(LOCW)) u_pair (
        .a   (mem[rd_idx[IW-1:0]]),
        .b   (mem[rd_nxt[IW-1:0]]),
        .dir (pair_dir),
        .ok  (pair_ok)
    );

    // Control state: FSM state, stack depth and replay index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= REC;
            count  <= '0;
            rd_idx <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            rd_idx <= rd_idx_next;
        end
    end

    // Location storage; contents survive reset, only count defines validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= locIn;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next  = state;
        count_next  = count;
        rd_idx_next = rd_idx;
        wr_en       = 1'b0;
        wr_addr     = count[IW-1:0];
        valid       = 1'b0;
        dir         = DIR_YM;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            REC: begin
                if (start) begin
                    // A path needs at least two points to produce any move
                    rd_idx_next = '0;
                    state_next  = (count >= PW'(2)) ? RUN : FIN;
                end else if (push && pop && !empty) begin
                    wr_en   = 1'b1;
                    wr_addr = count_m1[IW-1:0];
                end else if (push && !full) begin
                    wr_en      = 1'b1;
                    count_next = count + PW'(1);
                end else if (pop && !empty) begin
                    count_next = count_m1;
                end
            end
            RUN: begin
                if (!pair_ok) begin
                    state_next = ERR;
                end else begin
                    valid = 1'b1;
                    dir   = pair_dir;
                    if (ready) begin
                        if (rd_idx + PW'(2) == count) begin
                            state_next = FIN;
                        end else begin
                            rd_idx_next = rd_nxt;
                        end
                    end
                end
            end
            FIN: begin
                done       = 1'b1;
                count_next = '0;
                state_next = REC;
            end
            ERR: begin
                err = 1'b1;
            end
            default: begin
                state_next = REC;
            end
        endcase
    end

endmodule
